// File: rtl/lmfe_top.sv
// lmfe_top: streaming 7x7 median filter over one IMG_W x IMG_H frame.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   Din        input pixel, sampled when in_en=1 and busy=0
//   in_en      input strobe from the pixel source
//   busy       registered; 1 = no pixel is accepted this cycle
//   out_valid  one-cycle strobe, Dout carries a filtered pixel
//   Dout       filtered pixel, raster order
//
// Build option
//   LMFE_REPLICATE_PAD_EN  defined: out-of-image window taps use the nearest
//                          in-image pixel; undefined (default): taps read 0.
//
// Pixels land in a circular store of WIN rows (row r lives in slot r % WIN).
// Outputs are produced as soon as the last pixel they depend on has been
// accepted: the window is gathered one column (WIN taps) per cycle, then the
// median is found by an MSB-first radix search over the 49 taps.
module lmfe_top #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DW    = 8,
  parameter int WIN   = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] Din,
  input  logic          in_en,
  output logic          busy,
  output logic          out_valid,
  output logic [DW-1:0] Dout
);
  localparam int CW   = $clog2(IMG_W);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int PW   = $clog2(NPIX + 1);
  localparam int SW   = $clog2(WIN);
  localparam int HALF = WIN / 2;
  localparam int NWIN = WIN * WIN;
  localparam int RANK = NWIN / 2 + 1;
  localparam int CNTW = $clog2(NWIN + 1);
  localparam int STW  = $clog2((DW > WIN) ? DW : WIN);

  typedef enum logic [2:0] {S_ACCEPT, S_LOAD, S_SEL, S_EMIT, S_DONE} state_t;

  state_t          state_q;
  logic [PW-1:0]   in_cnt_q;
  logic [PW-1:0]   out_cnt_q;
  logic [STW-1:0]  step_q;
  logic [DW-1:0]   res_q;
  logic            busy_q;
  logic            out_valid_q;
  logic [DW-1:0]   dout_q;
  logic [DW-1:0]   lb_q  [WIN][IMG_W];
  logic [DW-1:0]   win_q [NWIN];

  logic [DW-1:0]   col_pix [WIN];
  logic [DW-1:0]   trial;
  logic [DW-1:0]   res_d;
  logic [CNTW-1:0] lt_cnt;
  logic [PW-1:0]   out_nxt;
  logic [PW-1:0]   need_cur;
  logic [PW-1:0]   need_nxt;
  logic [SW-1:0]   in_slot;
  logic [CW-1:0]   in_col;
  int              o_row, o_col, w_row, w_col;

  // Index of the last input pixel that output index oi depends on.
  function automatic logic [PW-1:0] need_idx(input logic [PW-1:0] oi);
    int r, c;
    r = int'(oi) / IMG_W;
    c = int'(oi) % IMG_W;
    r = (r + HALF > IMG_H - 1) ? IMG_H - 1 : r + HALF;
    c = (c + HALF > IMG_W - 1) ? IMG_W - 1 : c + HALF;
    return PW'(r * IMG_W + c);
  endfunction

  function automatic logic [SW-1:0] slot_of(input int row);
    return SW'(row % WIN);
  endfunction

  function automatic int clampi(input int v, input int n);
    return (v < 0) ? 0 : ((v > n - 1) ? n - 1 : v);
  endfunction

  assign out_nxt  = out_cnt_q + PW'(1);
  assign need_cur = need_idx(out_cnt_q);
  assign need_nxt = need_idx(out_nxt);
  assign in_slot  = slot_of(int'(in_cnt_q) / IMG_W);
  assign in_col   = in_cnt_q[CW-1:0];

  // Window gather: column step_q of the window around the current output.
  always_comb begin
    o_row = int'(out_cnt_q) / IMG_W;
    o_col = int'(out_cnt_q) % IMG_W;
    w_col = o_col - HALF + int'(step_q);
    w_row = 0;
    for (int i = 0; i < WIN; i++) begin
      w_row = o_row - HALF + i;
      col_pix[i] = '0;
`ifdef LMFE_REPLICATE_PAD_EN
      col_pix[i] = lb_q[slot_of(clampi(w_row, IMG_H))][CW'(clampi(w_col, IMG_W))];
`else
      if (w_row >= 0 && w_row < IMG_H && w_col >= 0 && w_col < IMG_W)
        col_pix[i] = lb_q[slot_of(w_row)][CW'(w_col)];
`endif
    end
  end

  // Radix select: the median is the largest x with fewer than RANK taps below x.
  always_comb begin
    trial  = res_q | (DW'(1) << step_q);
    lt_cnt = '0;
    for (int k = 0; k < NWIN; k++)
      lt_cnt = lt_cnt + CNTW'(win_q[k] < trial);
    res_d = (lt_cnt < CNTW'(RANK)) ? trial : res_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_ACCEPT;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      step_q      <= '0;
      res_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < IMG_W; c++)
          lb_q[r][c] <= '0;
      for (int k = 0; k < NWIN; k++)
        win_q[k] <= '0;
    end else begin
      case (state_q)
        S_ACCEPT: begin
          if (in_en && !busy_q) begin
            lb_q[in_slot][in_col] <= Din;
            in_cnt_q <= in_cnt_q + PW'(1);
            // Outputs are drained eagerly, so the pending one can only
            // become computable on exactly this pixel.
            if (need_cur == in_cnt_q) begin
              state_q <= S_LOAD;
              busy_q  <= 1'b1;
              step_q  <= '0;
            end
          end
        end
        // ---- window gather: one column per cycle ----
        S_LOAD: begin
          for (int i = 0; i < WIN; i++)
            win_q[int'(step_q) * WIN + i] <= col_pix[i];
          if (step_q == STW'(WIN - 1)) begin
            state_q <= S_SEL;
            step_q  <= STW'(DW - 1);
            res_q   <= '0;
          end else begin
            step_q <= step_q + STW'(1);
          end
        end
        // ---- median select: one result bit per cycle, MSB first ----
        S_SEL: begin
          res_q <= res_d;
          if (step_q == '0) begin
            state_q     <= S_EMIT;
            out_valid_q <= 1'b1;
            dout_q      <= res_d;
          end else begin
            step_q <= step_q - STW'(1);
          end
        end
        // ---- emit: out_valid is high for exactly this state ----
        S_EMIT: begin
          out_valid_q <= 1'b0;
          out_cnt_q   <= out_nxt;
          if (out_nxt == PW'(NPIX)) begin
            state_q <= S_DONE;
          end else if (need_nxt < in_cnt_q) begin
            state_q <= S_LOAD;
            step_q  <= '0;
          end else begin
            state_q <= S_ACCEPT;
            busy_q  <= 1'b0;
          end
        end
        S_DONE: begin
          in_cnt_q  <= '0;
          out_cnt_q <= '0;
          busy_q    <= 1'b0;
          state_q   <= S_ACCEPT;
        end
        default: begin
          state_q <= S_ACCEPT;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign Dout      = dout_q;

endmodule

// File: tb/tb_lmfe_top.sv
// tb_lmfe_top: directed bench for lmfe_top on a reduced 16x16 frame.
module tb_lmfe_top;
  localparam int W    = 16;
  localparam int H    = 16;
  localparam int DW   = 8;
  localparam int NPIX = W * H;
  localparam int OBUF = 8 * NPIX;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_en = 1'b0;
  logic [DW-1:0] Din = '0;
  logic          busy;
  logic          out_valid;
  logic [DW-1:0] Dout;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] obuf [OBUF];
  int   ocnt = 0;
  int   acc_cnt = 0;
  int   long_pulse = 0;
  logic ov_prev = 1'b0;

  lmfe_top #(.IMG_W(W), .IMG_H(H), .DW(DW), .WIN(7)) dut (
    .clk(clk), .reset(reset), .Din(Din), .in_en(in_en),
    .busy(busy), .out_valid(out_valid), .Dout(Dout)
  );

  always #5 clk = ~clk;

  // Output collector, sampled on the falling edge.
  always @(negedge clk) begin
    if (out_valid) begin
      if (ocnt < OBUF) obuf[ocnt] = Dout;
      ocnt++;
      if (ov_prev) long_pulse++;
    end
    ov_prev = out_valid;
  end

  // Pixels the DUT takes: strobe high while busy low at the rising edge.
  always @(posedge clk) if (reset && in_en && !busy) acc_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pixel(input int pat, input int idx);
    int r, c;
    r = idx / W;
    c = idx % W;
    case (pat)
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return (r == H / 2 && c == W / 2) ? 8'hFF : 8'h00;
      default: return 8'(c);
    endcase
  endfunction

  // Number of in-image positions in the 7-wide span centred on p.
  function automatic int span(input int p, input int n);
    int lo, hi;
    lo = (p - 3 < 0) ? 0 : p - 3;
    hi = (p + 3 > n - 1) ? n - 1 : p + 3;
    return hi - lo + 1;
  endfunction

  task automatic send_frame(input int pat, input int maxgap, input int npix);
    int idx, gap, guard;
    idx = 0; gap = 0; guard = 0;
    while (idx < npix && guard < NPIX * 64) begin
      @(negedge clk);
      guard++;
      if (gap > 0) begin
        in_en = 1'b0;
        gap--;
      end else if (!busy) begin
        in_en = 1'b1;
        Din   = pixel(pat, idx);
        idx++;
        if (maxgap > 0) gap = int'($urandom_range(0, maxgap));
      end else begin
        // Offered while busy: must be ignored.
        in_en = 1'b1;
        Din   = 8'hA5;
      end
    end
    @(negedge clk);
    in_en = 1'b0;
    Din   = '0;
    check("send_done", idx, npix);
  endtask

  task automatic wait_frame(input int start, input string tag);
    int n;
    n = 0;
    while (ocnt - start < NPIX && n < NPIX * 40) begin
      @(negedge clk);
      n++;
    end
    repeat (40) @(negedge clk);
    check({tag, "_count"}, ocnt - start, NPIX);
    check({tag, "_idle"}, busy, 0);
  endtask

  // kind 0: all zero, 1: all-0xFF zero padded, 3: ramp interior
  task automatic check_frame(input int start, input int kind, input string tag);
    int r, c, e;
    for (int i = 0; i < NPIX; i++) begin
      r = i / W;
      c = i % W;
      if (kind == 1) begin
        e = (span(r, H) * span(c, W) >= 25) ? 255 : 0;
        check($sformatf("%s(%0d,%0d)", tag, r, c), obuf[start + i], e);
      end else if (kind == 3) begin
        if (r >= 3 && r <= H - 4 && c >= 3 && c <= W - 4)
          check($sformatf("%s(%0d,%0d)", tag, r, c), obuf[start + i], c);
      end else begin
        check($sformatf("%s(%0d,%0d)", tag, r, c), obuf[start + i], 0);
      end
    end
  endtask

  initial begin
    int s, a;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", Dout, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // All-zero frame, back to back
    s = ocnt; a = acc_cnt;
    send_frame(0, 0, NPIX);
    wait_frame(s, "zero");
    check("zero_accepted", acc_cnt - a, NPIX);
    check_frame(s, 0, "zero");

    // All-0xFF frame, zero padding at the borders
    s = ocnt; a = acc_cnt;
    send_frame(1, 0, NPIX);
    wait_frame(s, "ff");
    check("ff_accepted", acc_cnt - a, NPIX);
    check("ff_00", obuf[s + 0], 8'h00);
    check("ff_01", obuf[s + 1], 8'h00);
    check("ff_02", obuf[s + 2], 8'h00);
    check("ff_10", obuf[s + W], 8'h00);
    check("ff_03", obuf[s + 3], 8'hFF);
    check("ff_11", obuf[s + W + 1], 8'hFF);
    check("ff_22", obuf[s + 2 * W + 2], 8'hFF);
    check("ff_corner_br", obuf[s + NPIX - 1], 8'h00);
    check("ff_corner_tr", obuf[s + W - 1], 8'h00);
    check_frame(s, 1, "ff");

    // Single impulse is removed
    s = ocnt;
    send_frame(2, 0, NPIX);
    wait_frame(s, "imp");
    check_frame(s, 0, "imp");

    // Ramp pixel(r,c)=c
    s = ocnt;
    send_frame(3, 0, NPIX);
    wait_frame(s, "ramp");
    check_frame(s, 3, "ramp");

    // All-0xFF frame with random input gaps
    s = ocnt; a = acc_cnt;
    send_frame(1, 20, NPIX);
    wait_frame(s, "gap");
    check("gap_accepted", acc_cnt - a, NPIX);
    check_frame(s, 1, "gap");

    // Mid-frame reset, then a clean zero frame
    send_frame(1, 0, 100);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_dout", Dout, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    s = ocnt; a = acc_cnt;
    send_frame(0, 0, NPIX);
    wait_frame(s, "mrst");
    check("mrst_accepted", acc_cnt - a, NPIX);
    check_frame(s, 0, "mrst");

    check("one_cycle_valid", long_pulse, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lmfe_top.md
Name: lmfe_top

Overview:
- Local Median Filter Engine: streaming 7x7 median filter over one 128x128 8-bit greyscale frame.
- Pixels arrive in raster order through an in_en/busy handshake.
- Filtered pixels leave in raster order, one per out_valid pulse.
- Sits between a pixel source and a frame sink; top-level of the LMFE subsystem.

Parameters:
- IMG_W, 128, image width in pixels (power of 2).
- IMG_H, 128, image height in rows.
- DW, 8, pixel width in bits.
- WIN, 7, window size (fixed 7; centre offset 3).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- Din  in  DW  input pixel, valid when in_en=1.
- in_en  in  1  input strobe; pixel accepted at rising clk when in_en=1 and busy=0.
- busy  out  1  1 = block cannot accept a pixel this cycle.
- out_valid  out  1  one-cycle strobe; Dout holds a filtered pixel.
- Dout  out  DW  filtered pixel.

Behaviour:
- Reset (reset=0): busy=0, out_valid=0, Dout=0; input/output counters, line buffers and FSM cleared. Mid-frame reset aborts the frame; the next accepted pixel is (0,0).
- Output (r,c) = median of the 7x7 window rows r-3..r+3, cols c-3..c+3. Out-of-image positions count as 0 (zero padding).
- Median = 25th smallest of 49 values, unsigned compare; ties need no special handling.
- Exactly IMG_W*IMG_H outputs per frame, strictly raster order; out_valid high for exactly one cycle per output.
- busy is registered: changes only on rising clk, so the source samples it stably at negedge.
- Output (r,c) is computed once pixel (min(r+3,H-1), min(c+3,W-1)) is accepted; row-end and frame-end outputs need no later pixel.
- FSM states:
  - IDLE/ACCEPT (busy=0): waits for in_en.
  - COMPUTE (busy=1): sort/select for each newly computable output. Up to 4 outputs at row end; at frame end all remaining outputs.
  - EMIT: pulses out_valid, then back to ACCEPT, or to DONE after the last output.
- Per-output compute+emit <= 64 cycles; full frame done well under 10M cycles at any input rate.
- Storage: 6 line buffers of IMG_W x DW plus the current row; the window is built from them with zero substitution.
- Frame end: after all 16384 outputs, return to ACCEPT with counters at 0; the next accepted pixel starts a new frame.
- A pixel offered while input-complete but outputs remain pending: busy is 1, so it is not accepted.
- in_en=1 while busy=1: ignored, no state change.

Optional Feature:
- Macro LMFE_REPLICATE_PAD_EN.
- Defined: out-of-image window positions take the nearest in-image pixel (edge replication, coordinates clamped to 0..W-1 / 0..H-1).
- Undefined (default, golden-compatible): zero padding.
- Handshake and latency are identical in both builds.

Test Plan:
- All-zero frame -> 16384 outputs, all 0x00, raster order, each with a one-cycle out_valid.
- All-0xFF frame, zero padding:
  - 0x00 at (0,0), (0,1), (0,2), (1,0).
  - 0xFF at (0,3), (1,1), (2,2) and every interior pixel.
  - Mirrored values at the other corners.
- Zero frame with a single 0xFF impulse at (64,64) -> all outputs 0x00 (impulse removed).
- Ramp frame pixel(r,c)=c -> interior outputs (3<=r,c<=124) equal c; output count 16384.
- Source withholds in_en for random 0-20 cycles between pixels -> identical output stream to the back-to-back run; no pixel accepted while busy=1.
- Assert reset=0 after 5000 pixels, release, stream a full zero frame -> busy/out_valid/Dout read 0 during reset; exactly 16384 outputs follow, all 0x00.
